pipe_stage_chain: RTL and testbench
===================================

PIPE_STAGE_CHAIN -- requirements
Module: pipe_stage_chain

Interface
Parameters:
REQ-001 The block SHALL take parameter DATA_W, default 32: width of the datapath payload per stage.
REQ-002 The block SHALL take parameter CTRL_W, default 8: width of the control payload per stage (sized to pipe_pkg::control_t).
REQ-003 The block SHALL take parameter DEPTH, default 1, legal 1..4: number of register stages.
REQ-004 The block SHALL take parameter STALL_BUBBLE, default 1: 1 = control outputs forced 0 while stall=1; 0 = outputs hold the last stage unchanged.

Ports:
REQ-005 The block SHALL have port clk, in, 1: sole clock, rising edge.
REQ-006 The block SHALL have port rst, in, 1: synchronous, active-high reset.
REQ-007 The block SHALL have port stall, in, 1: freezes all stages.
REQ-008 The block SHALL have port flush, in, 1: invalidates all stages.
REQ-009 The block SHALL have port kill_mask, in, DEPTH: per-stage invalidate; bit 0 is the stage nearest the input.
REQ-010 The block SHALL have port valid_i, in, 1: upstream slot holds a real instruction.
REQ-011 The block SHALL have port ctrl_i, in, CTRL_W: upstream control fields.
REQ-012 The block SHALL have port data_i, in, DATA_W: upstream datapath fields.
REQ-013 The block SHALL have port valid_o, out, 1: last stage valid.
REQ-014 The block SHALL have port ctrl_o, out, CTRL_W: last stage control, gated.
REQ-015 The block SHALL have port data_o, out, DATA_W: last stage datapath, ungated.
REQ-016 The block SHALL have port occupancy, out, $clog2(DEPTH+1): count of valid stages.

Function
REQ-017 Each stage SHALL register {valid, ctrl, data}; with no stall, flush or kill, stage k loads stage k-1 (stage 0 loads the inputs) each rising edge.
REQ-018 Latency from inputs to outputs SHALL be exactly DEPTH cycles when stall=0 throughout.
REQ-019 When stall=1 and flush=0, every stage SHALL hold its valid, ctrl and data; the input is dropped, because upstream holds it.
REQ-020 When flush=1, every stage's valid and ctrl SHALL clear to 0 on the next edge; data is don't-care and holds. Flush overrides stall and kill_mask.
REQ-021 When kill_mask[k]=1 and flush=0, stage k's valid and ctrl SHALL clear at the next edge instead of loading or holding; other stages behave per REQ-017/019.
REQ-022 On kill with stall=0, the bubble SHALL be written into stage k; data still advances.
REQ-023 When valid_i=0, stage 0 SHALL capture ctrl=0 regardless of ctrl_i.
REQ-024 ctrl_o SHALL equal the last stage ctrl when valid_o=1, else 0.
REQ-025 With STALL_BUBBLE=1 and stall=1, ctrl_o and valid_o SHALL be 0 while data_o still reflects the held stage.
REQ-026 data_o SHALL always equal the last stage data register; it is never gated.
REQ-027 occupancy SHALL be the combinational popcount of the stage valid bits; its range is 0..DEPTH with no wrap.
REQ-028 Outputs SHALL be driven from registers only, with gating logic allowed; there SHALL be no combinational path from any *_i input to any output.

Reset
REQ-029 While rst=1 at a rising edge, all stage valid, ctrl and data registers SHALL load 0.
REQ-030 rst SHALL have priority over flush, stall and kill_mask.
REQ-031 After reset, valid_o=0, ctrl_o=0, data_o=0 and occupancy=0 until new valid data propagates.
REQ-032 Reset asserted mid-stall SHALL clear all stages; stall SHALL NOT preserve contents across reset.

Structure
REQ-033 pipe_pkg SHALL hold control_t (reg_wr, mem_wr, mem_rd, mem_mask[2:0], sel_wb[1:0]; 8 bits) and the constant MAX_PIPE_DEPTH=4.
REQ-034 One stage SHALL be a sub-module, pipe_stage_slot, instantiated DEPTH times by a generate loop.
REQ-035 An elaboration-time check SHALL reject DEPTH outside 1..MAX_PIPE_DEPTH.

Verification
(All scenarios use DEPTH=2, DATA_W=32, CTRL_W=8.)
REQ-036 Stream: valid_i=1, ctrl_i=8'h81 with data_i=32'hA, then 32'hB on consecutive cycles -> data_o=A and ctrl_o=8'h81 at cycle 2, B at cycle 3; occupancy=2 in steady state.
REQ-037 Stall: stall=1 for 3 cycles mid-stream -> contents unchanged; STALL_BUBBLE=1 gives ctrl_o=0 with data_o held; STALL_BUBBLE=0 gives ctrl_o=8'h81; the stream resumes in order afterward.
REQ-038 Flush with stall: flush=1 and stall=1 together with both stages valid -> next cycle valid_o=0, ctrl_o=0, occupancy=0.
REQ-039 Kill: kill_mask=2'b01 with both stages valid -> one cycle later the output shows the old stage 0 instruction; on the following cycle valid_o=0 (bubble) and occupancy decreases by 1.
REQ-040 Reset: rst=1 for 1 cycle during a stall holding data_i=32'hDEADBEEF -> all outputs are 0 next cycle.
REQ-041 Invalid input: valid_i=0, ctrl_i=8'hFF -> after 2 cycles ctrl_o=0 and valid_o=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and limits for the pipeline stage chain.
//   control_t      : packed control payload carried alongside each instruction
//   MAX_PIPE_DEPTH : largest supported number of register stages
package pipe_pkg;

  localparam int MAX_PIPE_DEPTH = 4;

  typedef struct packed {
    logic       reg_wr;
    logic       mem_wr;
    logic       mem_rd;
    logic [2:0] mem_mask;
    logic [1:0] sel_wb;
  } control_t;

endpackage

// File: rtl/pipe_stage_slot.sv
// One register stage of the chain: holds {valid, ctrl, data}.
//   clk, rst            : rising-edge clock, synchronous active-high reset
//   i_stall             : hold contents
//   i_flush             : clear valid/ctrl (data holds); beats stall and kill
//   i_kill              : clear valid/ctrl; data still advances unless stalled
//   i_valid/ctrl/data   : contents of the previous stage (or gated inputs)
//   o_valid/ctrl/data   : registered contents of this stage
module pipe_stage_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic              i_kill,
  input  logic              i_valid,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_data  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else if (i_kill) begin
      // Bubble replaces the slot; payload keeps moving so data_o stays
      // a plain delayed copy of the input stream.
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      if (!i_stall) r_data <= i_data;
    end else if (!i_stall) begin
      r_valid <= i_valid;
      r_ctrl  <= i_ctrl;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_ctrl  = r_ctrl;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_chain.sv
// DEPTH-stage register pipeline with stall, flush and per-stage kill.
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   stall      : freeze every stage (input dropped)
//   flush      : invalidate every stage
//   kill_mask  : per-stage invalidate, bit 0 nearest the input
//   valid_i, ctrl_i, data_i : upstream slot
//   valid_o, ctrl_o         : last stage, gated (and bubbled on stall if STALL_BUBBLE)
//   data_o                  : last stage payload, never gated
//   occupancy               : number of valid stages
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int CTRL_W       = 8,
  parameter int DEPTH        = 1,
  parameter int STALL_BUBBLE = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic                       flush,
  input  logic [DEPTH-1:0]           kill_mask,
  input  logic                       valid_i,
  input  logic [CTRL_W-1:0]          ctrl_i,
  input  logic [DATA_W-1:0]          data_i,
  output logic                       valid_o,
  output logic [CTRL_W-1:0]          ctrl_o,
  output logic [DATA_W-1:0]          data_o,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH+1);

  if (DEPTH < 1 || DEPTH > MAX_PIPE_DEPTH) begin : g_bad_depth
    $error("pipe_stage_chain: DEPTH=%0d outside 1..%0d", DEPTH, MAX_PIPE_DEPTH);
  end

  // Index 0 is the (gated) input; index k+1 is the output of stage k.
  logic [DEPTH:0]             w_valid;
  logic [DEPTH:0][CTRL_W-1:0] w_ctrl;
  logic [DEPTH:0][DATA_W-1:0] w_data;
  logic [OCC_W-1:0]           w_occ;
  logic                       w_hide;

  assign w_valid[0] = valid_i;
  assign w_ctrl[0]  = valid_i ? ctrl_i : '0;
  assign w_data[0]  = data_i;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    pipe_stage_slot #(
      .DATA_W (DATA_W),
      .CTRL_W (CTRL_W)
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .i_stall (stall),
      .i_flush (flush),
      .i_kill  (kill_mask[k]),
      .i_valid (w_valid[k]),
      .i_ctrl  (w_ctrl[k]),
      .i_data  (w_data[k]),
      .o_valid (w_valid[k+1]),
      .o_ctrl  (w_ctrl[k+1]),
      .o_data  (w_data[k+1])
    );
  end

  always_comb begin
    w_occ = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      w_occ = w_occ + OCC_W'(w_valid[k]);
    end
  end

  assign w_hide    = (STALL_BUBBLE != 0) && stall;
  assign valid_o   = w_valid[DEPTH] && !w_hide;
  assign ctrl_o    = valid_o ? w_ctrl[DEPTH] : '0;
  assign data_o    = w_data[DEPTH];
  assign occupancy = w_occ;

endmodule

// File: tb/tb_pipe_stage_chain.sv
module tb_pipe_stage_chain;

  localparam int DW = 32;
  localparam int CW = 8;
  localparam int D  = 2;
  localparam int OW = $clog2(D+1);

  logic          clk = 1'b0;
  logic          rst, stall, flush, valid_i;
  logic [D-1:0]  kill_mask;
  logic [CW-1:0] ctrl_i;
  logic [DW-1:0] data_i;

  logic          valid_o_b1, valid_o_b0;
  logic [CW-1:0] ctrl_o_b1, ctrl_o_b0;
  logic [DW-1:0] data_o_b1, data_o_b0;
  logic [OW-1:0] occ_b1, occ_b0;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  pipe_stage_chain #(.DATA_W(DW), .CTRL_W(CW), .DEPTH(D), .STALL_BUBBLE(1)) u_dut_b1 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .kill_mask(kill_mask),
    .valid_i(valid_i), .ctrl_i(ctrl_i), .data_i(data_i),
    .valid_o(valid_o_b1), .ctrl_o(ctrl_o_b1), .data_o(data_o_b1), .occupancy(occ_b1));

  pipe_stage_chain #(.DATA_W(DW), .CTRL_W(CW), .DEPTH(D), .STALL_BUBBLE(0)) u_dut_b0 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .kill_mask(kill_mask),
    .valid_i(valid_i), .ctrl_i(ctrl_i), .data_i(data_i),
    .valid_o(valid_o_b0), .ctrl_o(ctrl_o_b0), .data_o(data_o_b0), .occupancy(occ_b0));

  // Reference: an array of instruction slots, slot D-1 is the one seen at the output.
  typedef struct {
    bit        v;
    bit [7:0]  c;
    bit [31:0] d;
  } slot_t;

  typedef struct {
    bit        v1;
    bit [7:0]  c1;
    bit        v0;
    bit [7:0]  c0;
    bit [31:0] d;
    int        occ;
  } exp_t;

  slot_t pipe[D];
  exp_t  exp_q[$];

  initial begin
    for (int k = 0; k < D; k++) pipe[k] = '{v: 1'b0, c: 8'h00, d: 32'h0};
  end

  task automatic model_step(input bit r, input bit s, input bit f, input bit [D-1:0] km,
                            input bit vi, input bit [7:0] ci, input bit [31:0] di);
    slot_t old[D];
    slot_t src;
    exp_t  e;
    old = pipe;
    for (int k = 0; k < D; k++) begin
      if (k == 0) src = '{v: vi, c: (vi ? ci : 8'h00), d: di};
      else        src = old[k-1];
      if (r) begin
        pipe[k] = '{v: 1'b0, c: 8'h00, d: 32'h0};
      end else if (f) begin
        pipe[k].v = 1'b0;
        pipe[k].c = 8'h00;
      end else if (km[k]) begin
        pipe[k].v = 1'b0;
        pipe[k].c = 8'h00;
        pipe[k].d = s ? old[k].d : src.d;
      end else if (!s) begin
        pipe[k] = src;
      end
    end
    e.occ = 0;
    for (int k = 0; k < D; k++) e.occ += int'(pipe[k].v);
    e.d  = pipe[D-1].d;
    e.v0 = pipe[D-1].v;
    e.c0 = pipe[D-1].v ? pipe[D-1].c : 8'h00;
    e.v1 = pipe[D-1].v && !s;
    e.c1 = e.v1 ? pipe[D-1].c : 8'h00;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of stimulus at the falling edge and record what both
  // instances must show after the following rising edge.
  task automatic step(input bit r, input bit s, input bit f, input bit [D-1:0] km,
                      input bit vi, input bit [7:0] ci, input bit [31:0] di);
    @(negedge clk);
    rst = r; stall = s; flush = f; kill_mask = km;
    valid_i = vi; ctrl_i = ci; data_i = di;
    model_step(r, s, f, km, vi, ci, di);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Waits for the edge that consumes the last stepped inputs.
  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (valid_o_b1 !== e.v1 || ctrl_o_b1 !== e.c1 || data_o_b1 !== e.d || int'(occ_b1) != e.occ ||
          valid_o_b0 !== e.v0 || ctrl_o_b0 !== e.c0 || data_o_b0 !== e.d || int'(occ_b0) != e.occ) begin
        n_miss++;
        $display("FAIL out@%0t: b1 v=%b c=%h d=%h occ=%0d | b0 v=%b c=%h d=%h occ=%0d ; expected b1 v=%b c=%h b0 v=%b c=%h d=%h occ=%0d",
                 $time, valid_o_b1, ctrl_o_b1, data_o_b1, occ_b1, valid_o_b0, ctrl_o_b0, data_o_b0, occ_b0,
                 e.v1, e.c1, e.v0, e.c0, e.d, e.occ);
      end
    end
  end

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; kill_mask = '0;
    valid_i = 1'b0; ctrl_i = '0; data_i = '0;

    step(1, 0, 0, 2'b00, 0, 8'h00, 32'h0);
    step(1, 0, 0, 2'b00, 0, 8'h00, 32'h0);
    after_edge();
    chk("reset_valid", 32'(valid_o_b1), 32'h0);
    chk("reset_data",  data_o_b1, 32'h0);
    chk("reset_occ",   32'(occ_b1), 32'h0);

    // Stream A, B, C: two-cycle latency.
    step(0, 0, 0, 2'b00, 1, 8'h81, 32'hA);
    step(0, 0, 0, 2'b00, 1, 8'h81, 32'hB);
    after_edge();
    chk("stream_data_A", data_o_b1, 32'hA);
    chk("stream_ctrl_A", 32'(ctrl_o_b1), 32'h81);
    step(0, 0, 0, 2'b00, 1, 8'h81, 32'hC);
    after_edge();
    chk("stream_data_B", data_o_b1, 32'hB);
    chk("stream_occ",    32'(occ_b1), 32'h2);

    // Three stall cycles: contents frozen, bubble only on the STALL_BUBBLE=1 copy.
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 2'b00, 1, 8'h81, 32'hD);
      after_edge();
      chk("stall_b1_ctrl", 32'(ctrl_o_b1), 32'h0);
      chk("stall_b1_data", data_o_b1, 32'hB);
      chk("stall_b0_ctrl", 32'(ctrl_o_b0), 32'h81);
      chk("stall_occ",     32'(occ_b1), 32'h2);
    end
    step(0, 0, 0, 2'b00, 1, 8'h81, 32'hD);
    after_edge();
    chk("resume_C", data_o_b1, 32'hC);
    step(0, 0, 0, 2'b00, 1, 8'h81, 32'hE);
    after_edge();
    chk("resume_D", data_o_b1, 32'hD);

    // Flush together with stall.
    step(0, 1, 1, 2'b00, 1, 8'h81, 32'hF);
    after_edge();
    chk("flush_valid", 32'(valid_o_b0), 32'h0);
    chk("flush_ctrl",  32'(ctrl_o_b0), 32'h0);
    chk("flush_occ",   32'(occ_b0), 32'h0);

    // Kill stage 0 with both stages valid.
    step(0, 0, 0, 2'b00, 1, 8'h42, 32'h10);
    step(0, 0, 0, 2'b00, 1, 8'h43, 32'h11);
    after_edge();
    chk("kill_pre_occ", 32'(occ_b1), 32'h2);
    step(0, 0, 0, 2'b01, 1, 8'h44, 32'h12);
    after_edge();
    chk("kill_shows_old_s0", data_o_b1, 32'h11);
    chk("kill_ctrl_old_s0",  32'(ctrl_o_b1), 32'h43);
    step(0, 0, 0, 2'b00, 1, 8'h45, 32'h13);
    after_edge();
    chk("kill_bubble_valid", 32'(valid_o_b1), 32'h0);
    chk("kill_bubble_occ",   32'(occ_b1), 32'h1);
    chk("kill_data_advances", data_o_b1, 32'h12);

    // Reset in the middle of a stall.
    step(0, 1, 0, 2'b00, 1, 8'h81, 32'hDEADBEEF);
    step(1, 1, 0, 2'b00, 1, 8'h81, 32'hDEADBEEF);
    after_edge();
    chk("rst_stall_valid", 32'(valid_o_b0), 32'h0);
    chk("rst_stall_ctrl",  32'(ctrl_o_b0), 32'h0);
    chk("rst_stall_data",  data_o_b0, 32'h0);
    chk("rst_stall_occ",   32'(occ_b0), 32'h0);

    // Invalid input with all-ones control.
    step(0, 0, 0, 2'b00, 0, 8'hFF, 32'h55);
    step(0, 0, 0, 2'b00, 0, 8'hFF, 32'h66);
    after_edge();
    chk("inv_ctrl",  32'(ctrl_o_b0), 32'h0);
    chk("inv_valid", 32'(valid_o_b0), 32'h0);
    chk("inv_data",  data_o_b0, 32'h55);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      bit [D-1:0] km;
      for (int k = 0; k < D; k++) km[k] = ($urandom_range(0, 7) == 0);
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 15) == 0), km, ($urandom_range(0, 3) != 0),
           8'($urandom), $urandom);
    end
    step(0, 0, 0, 2'b00, 0, 8'h00, 32'h0);

    repeat (3) @(posedge clk);
    #3;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
